pc_fetch_stage: RTL and testbench

- Fetch stage of the RV32I core: PC register, next-PC selection and the IF/ID pipeline register.
- Consumes PCSrc from branch control and the branch target from the execute adder.
- Drives the instruction-memory address and presents the fetched instruction, its PC and PC+4 to decode.
- Handles decode stalls and branch-redirect flushes.

---
 rtl/pc_fetch_stage.sv | 100 ++++++++++
 tb/tb_pc_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// RV32I fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// A taken redirect beats any stall and flushes IF/ID to a NOP bubble.
module pc_fetch_stage #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            Stall_F,
  input  logic            Stall_D,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PC_F,
  output logic [31:0]     Instr_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
  output logic            Valid_D,
  output logic            Misalign_Err
);

  localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_target_aligned;
  logic            w_target_misaligned;
  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc_plus4_d;
  logic            r_valid_d;
  logic            r_misalign;

  // Wraps modulo 2^XLEN by construction; no overflow flag is wanted.
  assign w_pc_plus4          = r_pc + PC_INC;
  assign w_target_aligned    = {PCTarget[XLEN-1:2], 2'b00};
  assign w_target_misaligned = (PCTarget[1:0] != 2'b00);

  // Next-PC selection: redirect, then stall, then sequential.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (PCSrc) begin
      w_pc_next = w_target_aligned;
    end else if (Stall_F) begin
      w_pc_next = r_pc;
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID register: flush on redirect, hold on decode stall, else capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (PCSrc) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (!Stall_D) begin
      r_instr_d    <= imem_rdata;
      r_pc_d       <= r_pc;
      r_pc_plus4_d <= w_pc_plus4;
      r_valid_d    <= 1'b1;
    end
  end

  // One-cycle misaligned-target pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= PCSrc & w_target_misaligned;
    end
  end

  assign imem_addr    = r_pc;
  assign PC_F         = r_pc;
  assign Instr_D      = r_instr_d;
  assign PC_D         = r_pc_d;
  assign PCPlus4_D    = r_pc_plus4_d;
  assign Valid_D      = r_valid_d;
  assign Misalign_Err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage; a second instance
// starting at 0xFFFF_FFFC covers PC wrap-around.
module tb_pc_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        Stall_F;
  logic        Stall_D;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic        Valid_D;
  logic        Misalign_Err;

  logic        rst_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic [31:0] PC_F_w;
  logic [31:0] Instr_D_w;
  logic [31:0] PC_D_w;
  logic [31:0] PCPlus4_D_w;
  logic        Valid_D_w;
  logic        Misalign_Err_w;

  int checks;
  int errors;

  assign imem_rdata   = imem_addr ^ KEY;
  assign imem_rdata_w = imem_addr_w ^ KEY;

  pc_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D),
    .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D), .Misalign_Err(Misalign_Err)
  );

  pc_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst(rst_w), .PCSrc(1'b0), .PCTarget(32'h0000_0000),
    .Stall_F(1'b0), .Stall_D(1'b0), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .PC_F(PC_F_w), .Instr_D(Instr_D_w), .PC_D(PC_D_w),
    .PCPlus4_D(PCPlus4_D_w), .Valid_D(Valid_D_w), .Misalign_Err(Misalign_Err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_pcd,
                        input logic exp_v);
    checks++;
    if (PC_F !== exp_pc) begin errors++; $display("FAIL %s PC_F got %h exp %h", name, PC_F, exp_pc); end
    checks++;
    if (PC_D !== exp_pcd) begin errors++; $display("FAIL %s PC_D got %h exp %h", name, PC_D, exp_pcd); end
    checks++;
    if (Valid_D !== exp_v) begin errors++; $display("FAIL %s Valid_D got %b exp %b", name, Valid_D, exp_v); end
  endtask

  task automatic test_reset();
    rst = 1'b1; PCSrc = 1'b0; PCTarget = 32'h0; Stall_F = 1'b0; Stall_D = 1'b0;
    step(); rst = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1; #1;
    chk_pc("rst_async", 32'h0, 32'h0, 1'b0);
    checks++;
    if (Instr_D !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", Instr_D, NOP); end
    checks++;
    if (PCPlus4_D !== 32'h0) begin errors++; $display("FAIL rst_pcplus4 got %h exp 0", PCPlus4_D); end
    checks++;
    if (Misalign_Err !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", Misalign_Err); end
    step();
    #2 rst = 1'b0;
  endtask

  task automatic test_seq_fetch();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_pc("seq", 32'(4 * i), 32'(4 * (i - 1)), 1'b1);
      checks++;
      if (Instr_D !== (32'(4 * (i - 1)) ^ KEY)) begin
        errors++; $display("FAIL seq_instr got %h exp %h", Instr_D, 32'(4 * (i - 1)) ^ KEY);
      end
      checks++;
      if (PCPlus4_D !== 32'(4 * i)) begin errors++; $display("FAIL seq_pcplus4 got %h exp %h", PCPlus4_D, 32'(4 * i)); end
      checks++;
      if (imem_addr !== PC_F) begin errors++; $display("FAIL seq_imem_addr got %h exp %h", imem_addr, PC_F); end
    end
  endtask

  task automatic test_branch();
    PCSrc = 1'b1; PCTarget = 32'h40;
    step(); PCSrc = 1'b0;
    chk_pc("br_bubble", 32'h40, 32'h0, 1'b0);
    checks++;
    if (Instr_D !== NOP) begin errors++; $display("FAIL br_nop got %h exp %h", Instr_D, NOP); end
    step();
    chk_pc("br_target", 32'h44, 32'h40, 1'b1);
    checks++;
    if (Instr_D !== 32'hA5A5_0040) begin errors++; $display("FAIL br_instr got %h exp A5A50040", Instr_D); end
  endtask

  task automatic test_stall();
    PCSrc = 1'b1; PCTarget = 32'h1C;
    step(); PCSrc = 1'b0;
    step();
    chk_pc("stall_pre", 32'h20, 32'h1C, 1'b1);
    Stall_F = 1'b1; Stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pc("stall_hold", 32'h20, 32'h1C, 1'b1);
      checks++;
      if (Instr_D !== 32'hA5A5_001C) begin errors++; $display("FAIL stall_instr got %h exp A5A5001C", Instr_D); end
      checks++;
      if (imem_addr !== 32'h20) begin errors++; $display("FAIL stall_imem got %h exp 20", imem_addr); end
    end
    Stall_F = 1'b0; Stall_D = 1'b0;
    step();
    chk_pc("stall_resume", 32'h24, 32'h20, 1'b1);
    checks++;
    if (Instr_D !== 32'hA5A5_0020) begin errors++; $display("FAIL stall_resume_instr got %h exp A5A50020", Instr_D); end
  endtask

  task automatic test_redirect_in_stall();
    Stall_F = 1'b1; Stall_D = 1'b1; PCSrc = 1'b1; PCTarget = 32'h100;
    step(); PCSrc = 1'b0; Stall_F = 1'b0; Stall_D = 1'b0;
    chk_pc("rd_stall", 32'h100, 32'h0, 1'b0);
    checks++;
    if (Instr_D !== NOP) begin errors++; $display("FAIL rd_stall_nop got %h exp %h", Instr_D, NOP); end
    checks++;
    if (Misalign_Err !== 1'b0) begin errors++; $display("FAIL rd_stall_misalign got %b exp 0", Misalign_Err); end
  endtask

  task automatic test_misalign();
    PCSrc = 1'b1; PCTarget = 32'h102;
    step(); PCSrc = 1'b0;
    chk_pc("mis_redirect", 32'h100, 32'h0, 1'b0);
    checks++;
    if (Misalign_Err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", Misalign_Err); end
    step();
    chk_pc("mis_after", 32'h104, 32'h100, 1'b1);
    checks++;
    if (Misalign_Err !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", Misalign_Err); end
  endtask

  task automatic test_stall_f_only();
    Stall_F = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_pc("stallf_only", 32'h104, 32'h104, 1'b1);
      checks++;
      if (Instr_D !== 32'hA5A5_0104) begin errors++; $display("FAIL stallf_instr got %h exp A5A50104", Instr_D); end
    end
    Stall_F = 1'b0;
    step();
    chk_pc("stallf_release", 32'h108, 32'h104, 1'b1);
  endtask

  task automatic test_back_to_back();
    PCSrc = 1'b1; PCTarget = 32'h80;
    step();
    chk_pc("b2b_first", 32'h80, 32'h0, 1'b0);
    PCTarget = 32'h200;
    step(); PCSrc = 1'b0;
    chk_pc("b2b_second", 32'h200, 32'h0, 1'b0);
    step();
    chk_pc("b2b_after", 32'h204, 32'h200, 1'b1);
  endtask

  task automatic test_reset_mid_redirect();
    PCSrc = 1'b1; PCTarget = 32'h300;
    #2 rst = 1'b1; #1;
    chk_pc("rst_mid", 32'h0, 32'h0, 1'b0);
    step();
    #2 rst = 1'b0; PCSrc = 1'b0;
    step();
    chk_pc("rst_mid_after", 32'h4, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    #2 rst_w = 1'b0; #1;
    checks++;
    if (PC_F_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h exp FFFFFFFC", PC_F_w); end
    step();
    checks++;
    if (PC_F_w !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", PC_F_w); end
    checks++;
    if (PCPlus4_D_w !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got %h exp 0", PCPlus4_D_w); end
    checks++;
    if (PC_D_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcd got %h exp FFFFFFFC", PC_D_w); end
    checks++;
    if (Instr_D_w !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_instr got %h exp 5A5AFFFC", Instr_D_w); end
    checks++;
    if (Valid_D_w !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", Valid_D_w); end
  endtask

  initial begin
    checks = 0; errors = 0; rst_w = 1'b1;
    test_reset();
    test_seq_fetch();
    test_branch();
    test_stall();
    test_redirect_in_stall();
    test_misalign();
    test_stall_f_only();
    test_back_to_back();
    test_reset_mid_redirect();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
